// File: rtl/picomips_ctrl_if.sv
// Controller <-> datapath/decoder/memory signal bundle for the picoMIPS sequencer.
// master = sequencer side, slave = environment (memory, decoder, ALU, switches).
interface picomips_ctrl_if #(
  parameter int I_WIDTH      = 12,
  parameter int OPCODE_WIDTH = 6,
  parameter int PC_WIDTH     = 8
);
  logic [I_WIDTH-1:0]      instr;
  logic [OPCODE_WIDTH-1:0] opcode;
  logic [2:0]              offset;
  logic                    zero;
  logic                    in_valid;
  logic [PC_WIDTH-1:0]     pc;
  logic [I_WIDTH-1:0]      ir;
  logic [1:0]              alu_op;
  logic                    reg_we;
  logic                    mul_start;
  logic                    in_ready;
  logic                    halted;
  logic                    illegal;

  modport master (
    input  instr, opcode, offset, zero, in_valid,
    output pc, ir, alu_op, reg_we, mul_start, in_ready, halted, illegal
  );
  modport slave (
    output instr, opcode, offset, zero, in_valid,
    input  pc, ir, alu_op, reg_we, mul_start, in_ready, halted, illegal
  );
endinterface

// File: rtl/picomips_ctrl.sv
// picoMIPS multi-cycle sequencer: owns PC and IR, steps fetch/execute,
// stalls on the multiplier and on the switch-input handshake.
module picomips_ctrl #(
  parameter int I_WIDTH      = 12,
  parameter int OPCODE_WIDTH = 6,
  parameter int PC_WIDTH     = 8,
  parameter int MUL_CYCLES   = 3
) (
  input  logic           clk,
  input  logic           reset,
  picomips_ctrl_if.master bus
);
  localparam int CW = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;

  localparam logic [OPCODE_WIDTH-1:0] OP_NOP  = OPCODE_WIDTH'(0);
  localparam logic [OPCODE_WIDTH-1:0] OP_ADDI = OPCODE_WIDTH'(1);
  localparam logic [OPCODE_WIDTH-1:0] OP_ADD  = OPCODE_WIDTH'(2);
  localparam logic [OPCODE_WIDTH-1:0] OP_MUL  = OPCODE_WIDTH'(3);
  localparam logic [OPCODE_WIDTH-1:0] OP_LDSW = OPCODE_WIDTH'(4);
  localparam logic [OPCODE_WIDTH-1:0] OP_BEQ  = OPCODE_WIDTH'(5);
  localparam logic [OPCODE_WIDTH-1:0] OP_HALT = OPCODE_WIDTH'(6);

  typedef enum logic [2:0] {S_FETCH, S_EXEC, S_WAIT_MUL, S_WAIT_IN, S_HALT} state_t;

  state_t              state;
  logic [CW-1:0]       cnt;
  logic [PC_WIDTH-1:0] pc_q;
  logic [I_WIDTH-1:0]  ir_q;
  logic                halted_q;
  logic [PC_WIDTH-1:0] pc_inc, pc_br;

  assign pc_inc = pc_q + PC_WIDTH'(1);
  // Branch target: sign-extended 3-bit offset, sum truncated so negatives wrap high.
  assign pc_br  = pc_q + {{(PC_WIDTH-3){bus.offset[2]}}, bus.offset};

  assign bus.pc     = pc_q;
  assign bus.ir     = ir_q;
  assign bus.halted = halted_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_FETCH;
      pc_q     <= '0;
      ir_q     <= '0;
      cnt      <= '0;
      halted_q <= 1'b0;
    end else begin
      case (state)
        S_FETCH: begin
          ir_q  <= bus.instr;
          state <= S_EXEC;
        end
        S_EXEC: begin
          case (bus.opcode)
            OP_MUL: begin
              cnt   <= CW'(MUL_CYCLES - 1);
              state <= S_WAIT_MUL;
            end
            OP_LDSW: state <= S_WAIT_IN;
            OP_BEQ: begin
              pc_q  <= bus.zero ? pc_br : pc_inc;
              state <= S_FETCH;
            end
            OP_HALT: begin
              halted_q <= 1'b1;
              state    <= S_HALT;
            end
            default: begin
              pc_q  <= pc_inc;
              state <= S_FETCH;
            end
          endcase
        end
        S_WAIT_MUL: begin
          if (cnt != '0) cnt <= cnt - CW'(1);
          else begin
            pc_q  <= pc_inc;
            state <= S_FETCH;
          end
        end
        S_WAIT_IN: begin
          if (bus.in_valid) begin
            pc_q  <= pc_inc;
            state <= S_FETCH;
          end
        end
        S_HALT:  state <= S_HALT;
        default: state <= S_FETCH;
      endcase
    end
  end

  // Strobes follow the state; in WAIT_IN the write lands in the same cycle as in_valid.
  always_comb begin
    bus.reg_we    = 1'b0;
    bus.mul_start = 1'b0;
    bus.in_ready  = 1'b0;
    bus.illegal   = 1'b0;
    bus.alu_op    = 2'd0;
    case (state)
      S_EXEC: begin
        case (bus.opcode)
          OP_ADDI: begin bus.reg_we = 1'b1; bus.alu_op = 2'd2; end
          OP_ADD:  begin bus.reg_we = 1'b1; bus.alu_op = 2'd1; end
          OP_MUL:  bus.mul_start = 1'b1;
          OP_NOP, OP_LDSW, OP_BEQ, OP_HALT: ;
          default: bus.illegal = 1'b1;
        endcase
      end
      S_WAIT_MUL: begin
        if (cnt == '0) begin
          bus.reg_we = 1'b1;
          bus.alu_op = 2'd3;
        end
      end
      S_WAIT_IN: begin
        bus.in_ready = 1'b1;
        bus.reg_we   = bus.in_valid;
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_picomips_ctrl.sv
// Bench for picomips_ctrl: directed scenarios with literal expectations plus
// randomized programs checked every cycle against an instruction-level model.
module tb_picomips_ctrl;
  localparam int MULC = 3;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  picomips_ctrl_if #(.I_WIDTH(12), .OPCODE_WIDTH(6), .PC_WIDTH(8)) bus ();

  picomips_ctrl #(.I_WIDTH(12), .OPCODE_WIDTH(6), .PC_WIDTH(8), .MUL_CYCLES(MULC)) dut (
    .clk(clk), .reset(reset), .bus(bus.master)
  );

  // Program memory and decoder stand-ins.
  logic [11:0] mem [256];
  assign bus.instr  = mem[bus.pc];
  assign bus.opcode = bus.ir[11:6];
  assign bus.offset = bus.ir[2:0];

  int ntests = 0;
  int nfail  = 0;

  // Model: PC, IR, cycle index within the current instruction, halted flag.
  logic [7:0]  mpc;
  logic [11:0] mir;
  int          k;
  logic        mhalt;
  logic        started = 1'b0;

  function automatic logic [11:0] mk(int op, int imm, int off);
    logic [5:0] o; logic [2:0] i; logic [2:0] f;
    o = 6'(op); i = 3'(imm); f = 3'(off);
    return {o, i, f};
  endfunction

  always @(posedge clk) begin
    int op;
    logic done;
    if (reset) begin
      mpc = 8'd0; mir = 12'd0; k = 0; mhalt = 1'b0; started = 1'b1;
    end else if (started && !mhalt) begin
      op = int'(mir[11:6]);
      if (k == 0) begin
        mir = mem[mpc];
        k   = 1;
      end else if (k == 1 && op == 6) begin
        mhalt = 1'b1;
      end else begin
        done = (op != 3 && op != 4 && k == 1) || (op == 3 && k == MULC + 1) ||
               (op == 4 && k >= 2 && bus.in_valid);
        if (done) begin
          if (op == 5 && bus.zero) mpc = 8'(int'(mpc) + int'($signed(mir[2:0])));
          else                     mpc = 8'(int'(mpc) + 1);
          k = 0;
        end else k = k + 1;
      end
    end
  end

  logic       e_we, e_ms, e_rdy, e_ill;
  logic [1:0] e_alu;
  always @(negedge clk) begin
    int op;
    if (started) begin
      op = int'(mir[11:6]);
      e_we = 1'b0; e_ms = 1'b0; e_rdy = 1'b0; e_ill = 1'b0; e_alu = 2'd0;
      if (!mhalt) begin
        if (k == 1) begin
          e_we  = (op == 1 || op == 2);
          e_alu = (op == 1) ? 2'd2 : (op == 2) ? 2'd1 : 2'd0;
          e_ms  = (op == 3);
          e_ill = (op > 6);
        end else if (k >= 2 && op == 3 && k == MULC + 1) begin
          e_we = 1'b1; e_alu = 2'd3;
        end else if (k >= 2 && op == 4) begin
          e_rdy = 1'b1; e_we = bus.in_valid;
        end
      end
      ntests++;
      if (bus.pc !== mpc || bus.ir !== mir || bus.halted !== mhalt || bus.reg_we !== e_we ||
          bus.mul_start !== e_ms || bus.in_ready !== e_rdy || bus.illegal !== e_ill ||
          bus.alu_op !== e_alu) begin
        nfail++;
        $display("FAIL cycle_cmp t=%0t got pc=%0d ir=%h h=%b we=%b ms=%b rdy=%b ill=%b alu=%0d exp pc=%0d ir=%h h=%b we=%b ms=%b rdy=%b ill=%b alu=%0d",
                 $time, bus.pc, bus.ir, bus.halted, bus.reg_we, bus.mul_start, bus.in_ready,
                 bus.illegal, bus.alu_op, mpc, mir, mhalt, e_we, e_ms, e_rdy, e_ill, e_alu);
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_nop();
    for (int i = 0; i < 256; i++) mem[i] = 12'h000;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic rand_prog();
    int r;
    for (int i = 0; i < 256; i++) begin
      r = int'($urandom_range(0, 15));
      if (r >= 14)     mem[i] = mk(int'($urandom_range(7, 63)), int'($urandom_range(0, 7)), int'($urandom_range(0, 7)));
      else if (r == 6) mem[i] = mk(($urandom_range(0, 3) == 0) ? 6 : 4, 0, 0);
      else             mem[i] = mk(r % 7 == 6 ? 5 : r % 7, int'($urandom_range(0, 7)), int'($urandom_range(0, 7)));
    end
  endtask

  initial begin
    int hc;
    bus.zero = 1'b0;
    bus.in_valid = 1'b0;
    fill_nop();

    // ADDI then NOP
    mem[0] = mk(1, 3, 0);
    do_reset();
    chk("rst_pc", int'(bus.pc), 0);
    chk("rst_ir", int'(bus.ir), 0);
    chk("rst_halted", int'(bus.halted), 0);
    chk("fetch_we", int'(bus.reg_we), 0);
    tick();
    chk("addi_we", int'(bus.reg_we), 1);
    chk("addi_alu", int'(bus.alu_op), 2);
    tick();
    chk("pc_after_addi", int'(bus.pc), 1);
    chk("fetch2_we", int'(bus.reg_we), 0);
    tick(); tick();
    chk("pc_after_nop", int'(bus.pc), 2);

    // BEQ -2 at pc 5, taken and not taken
    fill_nop();
    mem[5] = mk(5, 0, 6);
    bus.zero = 1'b1;
    do_reset();
    repeat (10) tick();
    chk("pc_at_5", int'(bus.pc), 5);
    tick();
    chk("beq_we", int'(bus.reg_we), 0);
    tick();
    chk("beq_taken", int'(bus.pc), 3);
    bus.zero = 1'b0;
    do_reset();
    repeat (12) tick();
    chk("beq_not_taken", int'(bus.pc), 6);

    // Wrap: BEQ +3 at 254, then run through 255 -> 0
    fill_nop();
    mem[254] = mk(5, 0, 3);
    bus.zero = 1'b1;
    do_reset();
    repeat (508) tick();
    chk("pc_at_254", int'(bus.pc), 254);
    tick(); tick();
    chk("beq_wrap", int'(bus.pc), 1);
    bus.zero = 1'b0;
    repeat (510) tick();
    chk("pc_wrap_255", int'(bus.pc), 0);

    // MUL timing
    fill_nop();
    mem[0] = mk(3, 0, 0);
    do_reset();
    tick();
    chk("mul_start", int'(bus.mul_start), 1);
    chk("mul_exec_we", int'(bus.reg_we), 0);
    tick();
    chk("mul_w1_we", int'(bus.reg_we), 0);
    chk("mul_w1_ms", int'(bus.mul_start), 0);
    tick();
    chk("mul_w2_we", int'(bus.reg_we), 0);
    tick();
    chk("mul_w3_we", int'(bus.reg_we), 1);
    chk("mul_w3_alu", int'(bus.alu_op), 3);
    tick();
    chk("mul_pc", int'(bus.pc), 1);

    // LDSW handshake with an early in_valid pulse during FETCH
    mem[0] = mk(4, 0, 0);
    do_reset();
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    chk("ldsw_exec_rdy", int'(bus.in_ready), 0);
    tick();
    chk("ldsw_rdy1", int'(bus.in_ready), 1);
    chk("ldsw_we1", int'(bus.reg_we), 0);
    tick(); tick(); tick();
    bus.in_valid = 1'b1;
    #1;
    chk("ldsw_rdy4", int'(bus.in_ready), 1);
    chk("ldsw_we4", int'(bus.reg_we), 1);
    chk("ldsw_alu", int'(bus.alu_op), 0);
    tick();
    bus.in_valid = 1'b0;
    chk("ldsw_pc", int'(bus.pc), 1);

    // Reset during WAIT_MUL, then HALT, then illegal opcode
    mem[0] = mk(3, 0, 0);
    do_reset();
    tick(); tick(); tick();
    reset = 1'b1;
    chk("mulrst_we", int'(bus.reg_we), 0);
    tick();
    reset = 1'b0;
    chk("mulrst_pc", int'(bus.pc), 0);
    chk("mulrst_we2", int'(bus.reg_we), 0);
    mem[0] = mk(6, 0, 0);
    tick(); tick();
    for (int i = 0; i < 20; i++) begin
      chk("halt_flag", int'(bus.halted), 1);
      chk("halt_pc", int'(bus.pc), 0);
      tick();
    end
    mem[0] = 12'hFC0;
    do_reset();
    tick();
    chk("illegal_pulse", int'(bus.illegal), 1);
    tick();
    chk("illegal_clear", int'(bus.illegal), 0);
    chk("illegal_pc", int'(bus.pc), 1);

    // Randomized programs, handshakes, flags and resets
    rand_prog();
    do_reset();
    hc = 0;
    for (int c = 0; c < 3000; c++) begin
      bus.zero     = 1'($urandom_range(0, 1));
      bus.in_valid = ($urandom_range(0, 2) == 0);
      hc = mhalt ? hc + 1 : 0;
      if (hc > 3 || $urandom_range(0, 199) == 0) begin
        reset = 1'b1;
        rand_prog();
      end else reset = 1'b0;
      tick();
    end
    reset = 1'b0;

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule
